// File: rtl/opb_reg_slot_arbiter_pkg.sv
// rtl/opb_reg_slot_arbiter_pkg.sv - shared constants for the OPB register-slot arbiter
package opb_reg_slot_arbiter_pkg;

    localparam int OPB_DW    = 32;
    localparam int ERR_CNT_W = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ERR    = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/opb_reg_slot_arbiter_if.sv
// rtl/opb_reg_slot_arbiter_if.sv - OPB-side and slave-side signal bundle of the arbiter
interface opb_reg_slot_arbiter_if #(
    parameter int N_SLAVES = 4,
    parameter int ERR_W    = opb_reg_slot_arbiter_pkg::ERR_CNT_W
);
    localparam int DW = opb_reg_slot_arbiter_pkg::OPB_DW;

    logic [0:DW-1]          OPB_ABus;
    logic                   OPB_select;
    logic                   OPB_RNW;
    logic [N_SLAVES-1:0]    slv_select;
    logic [DW*N_SLAVES-1:0] slv_DBus;
    logic [N_SLAVES-1:0]    slv_xferAck;
    logic [N_SLAVES-1:0]    slv_toutSup;
    logic [0:DW-1]          Sl_DBus;
    logic                   Sl_xferAck;
    logic                   Sl_errAck;
    logic                   Sl_retry;
    logic                   Sl_toutSup;
    logic                   slv_rnw;
    logic [ERR_W-1:0]       err_count;

    modport slave (
        input  OPB_ABus, OPB_select, OPB_RNW, slv_DBus, slv_xferAck, slv_toutSup,
        output slv_select, Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup,
               slv_rnw, err_count
    );

    modport master (
        output OPB_ABus, OPB_select, OPB_RNW, slv_DBus, slv_xferAck, slv_toutSup,
        input  slv_select, Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup,
               slv_rnw, err_count
    );

endinterface

// File: rtl/opb_reg_slot_arbiter_decode.sv
// rtl/opb_reg_slot_arbiter_decode.sv - combinational OPB address to slot decoder
module opb_slot_decode #(
    parameter int          N_SLAVES   = 4,
    parameter logic [31:0] C_BASEADDR = 32'h0100_8000,
    parameter int          SLOT_LOG2  = 8,
    parameter int          IDX_W      = 2
) (
    input  logic [31:0]      addr_i,
    output logic [IDX_W-1:0] slot_o,
    output logic             mapped_o
);
    logic [31:0] offset;
    logic [31:0] slot_full;

    // Addresses below the base wrap to a huge offset, so the explicit >= test keeps them unmapped.
    assign offset    = addr_i - C_BASEADDR;
    assign slot_full = offset >> SLOT_LOG2;
    assign slot_o    = slot_full[IDX_W-1:0];
    assign mapped_o  = (addr_i >= C_BASEADDR) && (slot_full < 32'(N_SLAVES));

endmodule

// File: rtl/opb_reg_slot_arbiter.sv
// rtl/opb_reg_slot_arbiter.sv - OPB slot decode, slave select, ack/timeout and error counting
module opb_reg_slot_arbiter
    import opb_reg_slot_arbiter_pkg::*;
#(
    parameter int          N_SLAVES   = 4,
    parameter logic [31:0] C_BASEADDR = 32'h0100_8000,
    parameter int          SLOT_LOG2  = 8,
    parameter int          TIMEOUT    = 16,
    parameter int          ERR_W      = ERR_CNT_W
) (
    input logic                    OPB_Clk,
    input logic                    OPB_Rst_n,
    opb_reg_slot_arbiter_if.slave  bus
);
    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    logic [1:0]          state_q, state_d;
    logic [IDX_W-1:0]    slot_q, slot_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [N_SLAVES-1:0] sel_q, sel_d;
    logic [OPB_DW-1:0]   dbus_q, dbus_d;
    logic                xack_q, xack_d;
    logic                eack_q, eack_d;
    logic                tsup_q, tsup_d;
    logic [ERR_W-1:0]    errc_q, errc_d;

    logic [IDX_W-1:0]    dec_slot;
    logic                dec_mapped;
    logic [OPB_DW-1:0]   slv_rdata;
    logic                slot_ack;
    logic                slot_tsup;

    opb_slot_decode #(
        .N_SLAVES   (N_SLAVES),
        .C_BASEADDR (C_BASEADDR),
        .SLOT_LOG2  (SLOT_LOG2),
        .IDX_W      (IDX_W)
    ) u_decode (
        .addr_i   (bus.OPB_ABus),
        .slot_o   (dec_slot),
        .mapped_o (dec_mapped)
    );

    // Only the latched slot is ever looked at; other slaves' acks are ignored.
    assign slv_rdata = bus.slv_DBus[{slot_q, 5'b00000} +: OPB_DW];
    assign slot_ack  = bus.slv_xferAck[slot_q];
    assign slot_tsup = bus.slv_toutSup[slot_q];

    // Next-state logic: transaction FSM, timeout counter and one-cycle ack pulses.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        cnt_d   = cnt_q;
        dbus_d  = '0;
        xack_d  = 1'b0;
        eack_d  = 1'b0;
        errc_d  = errc_q;
        sel_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.OPB_select) begin
                    if (dec_mapped) begin
                        slot_d  = dec_slot;
                        cnt_d   = 8'd0;
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_ACCESS: begin
                // Abort beats ack; ack beats a timeout landing in the same cycle.
                if (!bus.OPB_select) begin
                    state_d = ST_IDLE;
                end else if (slot_ack) begin
                    xack_d  = 1'b1;
                    dbus_d  = bus.OPB_RNW ? slv_rdata : '0;
                    state_d = ST_DONE;
                end else if (!slot_tsup) begin
                    if (cnt_q == 8'(TIMEOUT - 2)) begin
                        state_d = ST_ERR;
                    end
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_ERR: begin
                eack_d  = 1'b1;
                errc_d  = (errc_q == {ERR_W{1'b1}}) ? errc_q : errc_q + 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!bus.OPB_select) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_ACCESS) begin
            sel_d[slot_d] = 1'b1;
        end
        tsup_d = (state_q == ST_ACCESS) && (state_d == ST_ACCESS) && slot_tsup;
    end

    // State and output registers; reset drops every select and ack at once.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            dbus_q  <= '0;
            xack_q  <= 1'b0;
            eack_q  <= 1'b0;
            tsup_q  <= 1'b0;
            errc_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            dbus_q  <= dbus_d;
            xack_q  <= xack_d;
            eack_q  <= eack_d;
            tsup_q  <= tsup_d;
            errc_q  <= errc_d;
        end
    end

    assign bus.slv_select = sel_q;
    assign bus.Sl_DBus    = dbus_q;
    assign bus.Sl_xferAck = xack_q;
    assign bus.Sl_errAck  = eack_q;
    assign bus.Sl_retry   = 1'b0;
    assign bus.Sl_toutSup = tsup_q;
    assign bus.slv_rnw    = bus.OPB_RNW;
    assign bus.err_count  = errc_q;

endmodule

// File: tb/tb_opb_reg_slot_arbiter.sv
// tb/tb_opb_reg_slot_arbiter.sv - self-checking bench for opb_reg_slot_arbiter
module tb_opb_reg_slot_arbiter;
    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h0100_8000;
    localparam int          TO   = 16;

    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    opb_reg_slot_arbiter_if #(.N_SLAVES(N), .ERR_W(16)) bus ();
    opb_reg_slot_arbiter_if #(.N_SLAVES(N), .ERR_W(4))  bus_n ();

    assign bus_n.OPB_ABus    = bus.OPB_ABus;
    assign bus_n.OPB_select  = bus.OPB_select;
    assign bus_n.OPB_RNW     = bus.OPB_RNW;
    assign bus_n.slv_DBus    = bus.slv_DBus;
    assign bus_n.slv_xferAck = bus.slv_xferAck;
    assign bus_n.slv_toutSup = bus.slv_toutSup;

    opb_reg_slot_arbiter #(.N_SLAVES(N), .C_BASEADDR(BASE), .SLOT_LOG2(8), .TIMEOUT(TO), .ERR_W(16))
        dut (.OPB_Clk(clk), .OPB_Rst_n(rst_n), .bus(bus));

    opb_reg_slot_arbiter #(.N_SLAVES(N), .C_BASEADDR(BASE), .SLOT_LOG2(8), .TIMEOUT(TO), .ERR_W(4))
        dut_n (.OPB_Clk(clk), .OPB_Rst_n(rst_n), .bus(bus_n));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_mapped(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) / 32'd256) < 32'(N));
    endfunction

    // Behavioural model: transaction phase, elapsed unsuppressed wait, total errors raised.
    typedef enum int {M_IDLE, M_BUSY, M_ERR, M_DONE} mphase_t;
    mphase_t     m_phase;
    int          m_slot, m_wait, m_err;
    logic [3:0]  m_sel;
    logic        m_xack, m_eack, m_tsup;
    logic [31:0] m_dbus;

    always @(posedge clk or negedge rst_n) begin : model
        mphase_t     np;
        int          ns, nw, ne;
        logic        nx, nea, nt;
        logic [31:0] nd;
        logic [31:0] a;
        if (!rst_n) begin
            m_phase <= M_IDLE; m_slot <= 0; m_wait <= 0; m_err <= 0;
            m_sel <= '0; m_xack <= 1'b0; m_eack <= 1'b0; m_tsup <= 1'b0; m_dbus <= '0;
        end else begin
            np = m_phase; ns = m_slot; nw = m_wait; ne = m_err;
            nx = 1'b0; nea = 1'b0; nt = 1'b0; nd = '0;
            a = bus.OPB_ABus;
            case (m_phase)
                M_IDLE: if (bus.OPB_select) begin
                    if (is_mapped(a)) begin
                        ns = int'((a - BASE) / 32'd256); nw = 0; np = M_BUSY;
                    end else np = M_ERR;
                end
                M_BUSY: begin
                    if (!bus.OPB_select) np = M_IDLE;
                    else if (bus.slv_xferAck[m_slot]) begin
                        nx = 1'b1; np = M_DONE;
                        nd = bus.OPB_RNW ? bus.slv_DBus[32*m_slot +: 32] : 32'd0;
                    end else begin
                        if (!bus.slv_toutSup[m_slot]) nw = m_wait + 1;
                        if (nw == TO - 1) np = M_ERR;
                        else nt = bus.slv_toutSup[m_slot];
                    end
                end
                M_ERR: begin nea = 1'b1; ne = m_err + 1; np = M_DONE; end
                M_DONE: if (!bus.OPB_select) np = M_IDLE;
                default: np = M_IDLE;
            endcase
            m_phase <= np; m_slot <= ns; m_wait <= nw; m_err <= ne;
            m_sel   <= (np == M_BUSY) ? 4'(1 << ns) : 4'd0;
            m_xack <= nx; m_eack <= nea; m_tsup <= nt; m_dbus <= nd;
        end
    end

    // Every cycle: DUT outputs against the model, on the opposite clock edge.
    always @(negedge clk) begin
        chk("slv_select", bus.slv_select, m_sel);
        chk("Sl_xferAck", bus.Sl_xferAck, m_xack);
        chk("Sl_errAck", bus.Sl_errAck, m_eack);
        chk("Sl_DBus", bus.Sl_DBus, m_dbus);
        chk("Sl_toutSup", bus.Sl_toutSup, m_tsup);
        chk("Sl_retry", bus.Sl_retry, 1'b0);
        chk("slv_rnw", bus.slv_rnw, bus.OPB_RNW);
        chk("ack_exclusive", bus.Sl_xferAck & bus.Sl_errAck, 1'b0);
        chk("err_count", bus.err_count, (m_err > 65535) ? 65535 : m_err);
        chk("err_count_sat4", bus_n.err_count, (m_err > 15) ? 15 : m_err);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.OPB_select = 1'b0; bus.slv_xferAck = '0; bus.slv_toutSup = '0;
    endtask

    function automatic logic [31:0] rand_addr();
        int p;
        p = $urandom_range(0, 9);
        if (p <= 5) return BASE + 32'($urandom_range(0, N - 1)) * 32'd256 + (32'($urandom_range(0, 255)) & 32'hFC);
        if (p == 6) return BASE + 32'(N) * 32'd256 + (32'($urandom_range(0, 4095)) & 32'hFFC);
        if (p == 7) return BASE - 32'd4 - (32'($urandom_range(0, 255)) & 32'hFC);
        if (p == 8) return 32'hFFFF_FFFC;
        return $urandom;
    endfunction

    task automatic run_timeout(input string name, input int sup_cycles, input int exp_lat);
        int n;
        bus.OPB_ABus = BASE + 32'h100; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
        tick();
        chk({name, "_sel"}, bus.slv_select, 4'b0010);
        n = 0;
        while (n < 60 && bus.Sl_errAck !== 1'b1) begin
            bus.slv_toutSup = (n < sup_cycles) ? 4'b0010 : 4'b0000;
            tick();
            n++;
            if (n == 1 && sup_cycles > 0) chk({name, "_toutsup_echo"}, bus.Sl_toutSup, 1'b1);
        end
        chk({name, "_latency"}, n, exp_lat);
        idle_inputs();
        tick();
    endtask

    initial begin
        int xcount;
        int ack_pct;
        rst_n = 1'b0;
        bus.OPB_ABus = '0; bus.OPB_RNW = 1'b0; bus.slv_DBus = '0;
        idle_inputs();
        tick(); tick();
        chk("rst_select", bus.slv_select, 4'b0000);
        chk("rst_errcnt", bus.err_count, 16'd0);
        chk("rst_acks", {bus.Sl_xferAck, bus.Sl_errAck, bus.Sl_toutSup}, 3'b000);
        rst_n = 1'b1;
        tick();

        // Read slot 2; slave acks on the third edge after select.
        bus.OPB_ABus = 32'h0100_8200; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
        tick();
        chk("rd_select", bus.slv_select, 4'b0100);
        tick(); tick();
        chk("rd_no_ack_yet", bus.Sl_xferAck, 1'b0);
        bus.slv_DBus[64 +: 32] = 32'hDEAD_BEEF; bus.slv_xferAck = 4'b0100;
        tick();
        chk("rd_ack", bus.Sl_xferAck, 1'b1);
        chk("rd_data", bus.Sl_DBus, 32'hDEAD_BEEF);
        chk("rd_select_drop", bus.slv_select, 4'b0000);
        idle_inputs();
        tick();
        chk("rd_data_clear", bus.Sl_DBus, 32'h0);
        chk("rd_errcnt", bus.err_count, 16'd0);

        // Unmapped: first address above the last slot, then just below the base.
        bus.OPB_ABus = 32'h0100_8400; bus.OPB_select = 1'b1;
        tick();
        chk("unm_hi_select", bus.slv_select, 4'b0000);
        tick();
        chk("unm_hi_errack", bus.Sl_errAck, 1'b1);
        chk("unm_hi_errcnt", bus.err_count, 16'd1);
        idle_inputs();
        tick();
        bus.OPB_ABus = 32'h0100_7FFC; bus.OPB_select = 1'b1;
        tick(); tick();
        chk("unm_lo_errack", bus.Sl_errAck, 1'b1);
        chk("unm_lo_errcnt", bus.err_count, 16'd2);
        idle_inputs();
        tick();

        // Slave 1 silent: plain timeout, then timeout stretched by 10 suppressed cycles.
        run_timeout("tout", 0, 16);
        run_timeout("tout_sup", 10, 26);
        chk("tout_errcnt", bus.err_count, 16'd4);

        // Ack arriving on the very cycle the timeout would fire.
        bus.OPB_ABus = 32'h0100_8300; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
        tick();
        repeat (TO - 2) tick();
        chk("edge_no_err_yet", bus.Sl_errAck, 1'b0);
        bus.slv_DBus[96 +: 32] = 32'h1234_5678; bus.slv_xferAck = 4'b1000;
        tick();
        chk("edge_xack", bus.Sl_xferAck, 1'b1);
        chk("edge_no_eack", bus.Sl_errAck, 1'b0);
        chk("edge_data", bus.Sl_DBus, 32'h1234_5678);
        idle_inputs();
        tick();
        chk("edge_errcnt", bus.err_count, 16'd4);

        // Master abort during ACCESS.
        bus.OPB_ABus = 32'h0100_8000; bus.OPB_select = 1'b1;
        tick();
        chk("abort_sel", bus.slv_select, 4'b0001);
        bus.OPB_select = 1'b0;
        tick();
        chk("abort_drop", bus.slv_select, 4'b0000);
        tick();
        chk("abort_no_ack", {bus.Sl_xferAck, bus.Sl_errAck}, 2'b00);
        chk("abort_errcnt", bus.err_count, 16'd4);

        // Write with select and ack held high: exactly one ack, data forced to 0.
        bus.OPB_ABus = 32'h0100_8010; bus.OPB_RNW = 1'b0; bus.OPB_select = 1'b1;
        bus.slv_DBus[0 +: 32] = 32'hCAFE_F00D; bus.slv_xferAck = 4'b0001;
        xcount = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.Sl_xferAck === 1'b1) begin
                xcount++;
                chk("wr_data_zero", bus.Sl_DBus, 32'h0);
            end
        end
        chk("held_single_ack", xcount, 1);
        idle_inputs();
        tick();

        // Reset pulse in the middle of ACCESS.
        bus.OPB_ABus = 32'h0100_8200; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
        tick();
        chk("rstmid_sel", bus.slv_select, 4'b0100);
        rst_n = 1'b0;
        #1;
        chk("rstmid_sel_now", bus.slv_select, 4'b0000);
        chk("rstmid_acks", {bus.Sl_xferAck, bus.Sl_errAck}, 2'b00);
        idle_inputs();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rstmid_errcnt", bus.err_count, 16'd0);
        chk("rstmid_errcnt_n", bus_n.err_count, 4'd0);

        // Randomised traffic; the narrow instance is driven well past its saturation point.
        ack_pct = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0: ack_pct = 0;
                    1: ack_pct = 5;
                    default: ack_pct = 30;
                endcase
            end
            if (bus.OPB_select) begin
                if ($urandom_range(0, 19) == 0) bus.OPB_select = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
                bus.OPB_ABus = rand_addr();
                bus.OPB_RNW = 1'($urandom_range(0, 1));
                bus.OPB_select = 1'b1;
            end
            for (int k = 0; k < N; k++) begin
                bus.slv_xferAck[k] = ($urandom_range(0, 99) < ack_pct);
                bus.slv_toutSup[k] = ($urandom_range(0, 4) == 0);
                bus.slv_DBus[32*k +: 32] = $urandom;
            end
            tick();
        end
        chk("narrow_saturated", bus_n.err_count, 4'hF);
        idle_inputs();
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/opb_reg_slot_arbiter.md
Name: opb_reg_slot_arbiter

Overview:
- Sits between the OPB bus and a bank of N software-register slaves, such as the counter-reset and control registers of the testing2 design.
- Decodes the OPB address into a slot and drives a registered select to exactly one slave.
- Returns that slave's read data and acknowledge to the bus.
- Terminates a transaction with errAck when the address is unmapped or the slave does not answer within a bounded time. Keeps a saturating error count for software diagnostics.

Parameters:
- N_SLAVES, 4, number of register slaves (1..16)
- C_BASEADDR, 32'h01008000, byte address of slot 0
- SLOT_LOG2, 8, log2 of slot size in bytes (256-byte slots)
- TIMEOUT, 16, cycles to wait for slave ack before errAck (2..255)

Ports:
- OPB_Clk  in  1  clock
- OPB_Rst_n  in  1  asynchronous active-low reset
- OPB_ABus  in  [0:31]  bus address
- OPB_select  in  1  master transaction valid
- OPB_RNW  in  1  read-not-write, forwarded unchanged
- slv_select  out  [N_SLAVES-1:0]  one-hot select to slaves
- slv_DBus  in  [32*N_SLAVES-1:0]  slave read data; slot k uses bits [32k+31:32k]
- slv_xferAck  in  [N_SLAVES-1:0]  slave acks
- slv_toutSup  in  [N_SLAVES-1:0]  slave timeout suppress
- Sl_DBus  out  [0:31]  read data to bus
- Sl_xferAck  out  1  transfer ack
- Sl_errAck  out  1  error ack
- Sl_retry  out  1  tied 0
- Sl_toutSup  out  1  registered copy of the selected slave's toutSup
- slv_rnw  out  1  OPB_RNW passthrough
- err_count  out  16  saturating count of errAcks

Behaviour:
- Reset: all outputs 0, FSM in IDLE, timeout counter 0, err_count 0. The reset is asynchronous and active-low.
- Address decode (combinational):
  - offset = OPB_ABus - C_BASEADDR, unsigned 32-bit.
  - slot = offset >> SLOT_LOG2.
  - Mapped iff OPB_ABus >= C_BASEADDR and slot < N_SLAVES.
- FSM states: IDLE, ACCESS, ERR, DONE.
- IDLE:
  - If OPB_select=1 and the address is mapped: latch slot, set slv_select[slot]=1 on the next edge, clear the counter, go to ACCESS.
  - If OPB_select=1 and the address is unmapped: go to ERR.
- ACCESS:
  - Only the latched slot's xferAck and toutSup are examined; other slaves' acks are ignored.
  - On slv_xferAck[slot]=1: register Sl_DBus = slv_DBus[slot] if RNW=1, else 0. Pulse Sl_xferAck for 1 cycle on the next edge. Drop slv_select. Go to DONE.
  - Latency: Sl_xferAck is asserted 1 cycle after the slave ack.
  - The counter increments each cycle while slv_toutSup[slot]=0 and holds while it is 1.
  - When the counter reaches TIMEOUT-1 without an ack, go to ERR and drop slv_select.
  - If OPB_select falls (master abort): drop slv_select, go to IDLE, no ack, no error counted.
  - An ack arriving in the same cycle as the timeout limit wins: xferAck is returned and no error is raised.
- ERR: pulse Sl_errAck for exactly 1 cycle, increment err_count (saturating at 16'hFFFF), go to DONE.
- DONE: Sl_DBus returns to 0. Wait for OPB_select=0, then go to IDLE. This gives at least one idle cycle between transactions, and a held OPB_select never double-acks.
- Sl_xferAck and Sl_errAck are never asserted together.
- slv_select is one-hot or zero at all times.
- Sl_toutSup = registered slv_toutSup[slot] while in ACCESS, otherwise 0.
- Sl_DBus is 0 whenever Sl_xferAck=0, so it can be OR-combined on the OPB.
- Reset asserted mid-transaction: immediately clears slv_select and all acks. The FSM restarts in IDLE.

Decomposition:
- Shared package: FSM state encoding (IDLE=0, ACCESS=1, ERR=2, DONE=3), OPB data width 32, and the err_count width constant.
- One natural sub-module, opb_slot_decode: combinational address-to-slot decoder with a mapped flag, reusable by other OPB fabric blocks.
- The FSM, counter and muxing stay in the top module.

Test Plan:
- Read slot 2: ABus=0x01008200, RNW=1, slave 2 acks 3 cycles after select with DBus=0xDEADBEEF -> slv_select=4'b0100, Sl_xferAck 1 cycle after the slave ack with Sl_DBus=0xDEADBEEF, err_count=0.
- Unmapped address 0x01008400 with N=4 -> no slv_select, Sl_errAck pulse 2 cycles after select, err_count=1; address 0x01007FFC behaves the same.
- Slave 1 never acks, TIMEOUT=16 -> Sl_errAck 16 cycles after select asserts; slave 1 holding toutSup for 10 of those cycles extends the timeout to 26.
- Ack and timeout in the same cycle -> Sl_xferAck=1, Sl_errAck=0, err_count unchanged.
- Master aborts (OPB_select low during ACCESS), and separately a reset pulse mid-ACCESS -> slv_select=0 next cycle (abort) or immediately (reset), no ack; after reset, err_count=0.
- Force 65537 unmapped accesses -> err_count saturates at 0xFFFF; OPB_select held high after an ack -> only one ack is produced.
